// File: rtl/retire_monitor_pkg.sv
// Shared definitions for the retire monitor: address width and state encodings
// (the xgriscv_defines.v values), history geometry and a saturating increment.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef RM_ST_IDLE
`define RM_ST_IDLE    2'd0
`define RM_ST_RUN     2'd1
`define RM_ST_HALTED  2'd2
`define RM_ST_TIMEOUT 2'd3
`endif

package retire_monitor_pkg;

    localparam int AW = `ADDR_SIZE;

    localparam logic [1:0] ST_IDLE    = `RM_ST_IDLE;
    localparam logic [1:0] ST_RUN     = `RM_ST_RUN;
    localparam logic [1:0] ST_HALTED  = `RM_ST_HALTED;
    localparam logic [1:0] ST_TIMEOUT = `RM_ST_TIMEOUT;

    localparam int HIST_DEPTH = 8;
    localparam int HIST_PW    = 3;

    typedef logic [AW-1:0] addr_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Signal bundle for driving/observing a retire_monitor; master drives the
// writeback side, slave is the monitor's view.
interface retire_monitor_if;
    import retire_monitor_pkg::*;

    addr_t       pcW;
    logic        wb_valid;
    logic        clr;
    logic [2:0]  hist_idx;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    addr_t       last_pc;
    logic        halted;
    logic        timeout;
    addr_t       hist_pc;

    modport master (
        output pcW, wb_valid, clr, hist_idx,
        input  state, cycle_cnt, retire_cnt, last_pc, halted, timeout, hist_pc
    );

    modport slave (
        input  pcW, wb_valid, clr, hist_idx,
        output state, cycle_cnt, retire_cnt, last_pc, halted, timeout, hist_pc
    );

endinterface

// File: rtl/retire_monitor_hist.sv
// retire_hist_buf: 8-entry ring of retired PCs; idx 0 reads the newest entry.
// Only instantiated when RETIRE_TRACE_EN is defined.
module retire_hist_buf
    import retire_monitor_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr_i,
    input  logic               we_i,
    input  addr_t              pc_i,
    input  logic [HIST_PW-1:0] idx_i,
    output addr_t              pc_o
);

    addr_t              ring_q [HIST_DEPTH];
    logic [HIST_PW-1:0] wptr_q;
    logic [HIST_PW-1:0] rptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
        end else if (we_i) begin
            ring_q[wptr_q] <= pc_i;
            wptr_q         <= wptr_q + 3'd1;
        end
    end

    // 3-bit arithmetic gives the mod-8 wrap for free
    assign rptr = wptr_q - 3'd1 - idx_i;
    assign pc_o = ring_q[rptr];

endmodule

// File: rtl/retire_monitor.sv
// Retirement monitor: tracks run/halt/watchdog state and retirement counters.
// Optional PC trace ring enabled with `define RETIRE_TRACE_EN.
module retire_monitor
    import retire_monitor_pkg::*;
#(
    parameter logic [`ADDR_SIZE-1:0] HALT_ADDR  = 32'h0000_0078,
    parameter int unsigned           WDOG_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [`ADDR_SIZE-1:0] pcW,
    input  logic                  wb_valid,
    input  logic                  clr,
    output logic [1:0]            state,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           retire_cnt,
    output logic [`ADDR_SIZE-1:0] last_pc,
    output logic                  halted,
    output logic                  timeout,
    input  logic [2:0]            hist_idx,
    output logic [`ADDR_SIZE-1:0] hist_pc
);

    logic [1:0]  state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] idle_q, idle_d;
    addr_t       last_q, last_d;

    logic in_run;
    logic accept;
    logic hit_halt;
    logic wdog_exp;

    always_comb begin
        in_run   = (state_q == ST_RUN);
        accept   = wb_valid && !clr && (in_run || state_q == ST_IDLE);
        hit_halt = (pcW == HALT_ADDR);
        wdog_exp = in_run && !wb_valid && ((idle_q + 32'd1) >= 32'(WDOG_LIMIT));

        state_d = state_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        idle_d  = idle_q;
        last_d  = last_q;

        if (clr) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            ret_d   = '0;
            idle_d  = '0;
            last_d  = '0;
        end else begin
            if (in_run) begin
                cyc_d  = sat_inc(cyc_q);
                idle_d = idle_q + 32'd1;
            end
            // a halting retirement wins over a coincident watchdog expiry
            if (accept) begin
                ret_d   = sat_inc(ret_q);
                last_d  = pcW;
                idle_d  = '0;
                state_d = hit_halt ? ST_HALTED : ST_RUN;
            end else if (wdog_exp) begin
                idle_d  = '0;
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            ret_q   <= '0;
            idle_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            idle_q  <= idle_d;
            last_q  <= last_d;
        end
    end

    assign state      = state_q;
    assign cycle_cnt  = cyc_q;
    assign retire_cnt = ret_q;
    assign last_pc    = last_q;
    assign halted     = (state_q == ST_HALTED);
    assign timeout    = (state_q == ST_TIMEOUT);

`ifdef RETIRE_TRACE_EN
    retire_hist_buf u_hist (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (clr),
        .we_i  (accept),
        .pc_i  (pcW),
        .idx_i (hist_idx),
        .pc_o  (hist_pc)
    );
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// Scoreboard bench for retire_monitor: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_retire_monitor;
    import retire_monitor_pkg::*;

    localparam logic [31:0] HALT = 32'h78;
    localparam int          WDOG = 8;
    localparam longint      MAXC = 64'hFFFF_FFFF;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    retire_monitor_if rm_if ();

    always #5 clk = ~clk;

    retire_monitor #(.HALT_ADDR(HALT), .WDOG_LIMIT(WDOG)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pcW        (rm_if.pcW),
        .wb_valid   (rm_if.wb_valid),
        .clr        (rm_if.clr),
        .state      (rm_if.state),
        .cycle_cnt  (rm_if.cycle_cnt),
        .retire_cnt (rm_if.retire_cnt),
        .last_pc    (rm_if.last_pc),
        .halted     (rm_if.halted),
        .timeout    (rm_if.timeout),
        .hist_idx   (rm_if.hist_idx),
        .hist_pc    (rm_if.hist_pc)
    );

    typedef struct {
        int          st;
        longint      cyc;
        longint      ret;
        logic [31:0] pc;
        logic [31:0] hist;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model: abstract state number, wide counters, list of retired PCs
    int          m_st;
    longint      m_cyc, m_ret;
    logic [31:0] m_last;
    int          m_idle;
    logic [31:0] m_trace[$];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint sat(input longint x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_cyc = 0; m_ret = 0; m_last = '0; m_idle = 0;
        m_trace.delete();
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] pc, input bit c);
        if (c) begin
            model_reset();
        end else if (m_st == 0 || m_st == 1) begin
            if (m_st == 1) m_cyc = sat(m_cyc + 1);
            if (v) begin
                m_ret  = sat(m_ret + 1);
                m_last = pc;
                m_trace.push_back(pc);
                if (m_trace.size() > 8) void'(m_trace.pop_front());
                m_idle = 0;
                m_st   = (pc == HALT) ? 2 : 1;
            end else if (m_st == 1) begin
                m_idle++;
                if (m_idle >= WDOG) m_st = 3;
            end
        end
    endfunction

    function automatic logic [31:0] hist_exp(input int idx);
`ifdef RETIRE_TRACE_EN
        if (idx < m_trace.size()) return m_trace[m_trace.size() - 1 - idx];
`endif
        return 32'h0;
    endfunction

    function automatic void push_exp(input int idx);
        exp_t e;
        e.st = m_st; e.cyc = m_cyc; e.ret = m_ret; e.pc = m_last; e.hist = hist_exp(idx);
        expq.push_back(e);
    endfunction

    task automatic cycle(input bit v, input logic [31:0] pc, input bit c, input logic [2:0] idx);
        @(negedge clk);
        rstn = 1'b1;
        rm_if.wb_valid = v; rm_if.pcW = pc; rm_if.clr = c; rm_if.hist_idx = idx;
        model_step(v, pc, c);
        push_exp(int'(idx));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rstn = 1'b0;
        rm_if.wb_valid = 1'b0; rm_if.clr = 1'b0;
        model_reset();
        push_exp(int'(rm_if.hist_idx));
    endtask

    // registered outputs checked one step after each edge
    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("state",      longint'(rm_if.state),      longint'(e.st));
            chk("cycle_cnt",  longint'(rm_if.cycle_cnt),  e.cyc);
            chk("retire_cnt", longint'(rm_if.retire_cnt), e.ret);
            chk("last_pc",    longint'(rm_if.last_pc),    longint'(e.pc));
            chk("halted",     longint'(rm_if.halted),     longint'(e.st == 2));
            chk("timeout",    longint'(rm_if.timeout),    longint'(e.st == 3));
            chk("hist_pc",    longint'(rm_if.hist_pc),    longint'(e.hist));
        end
    end

    // reset must take effect without waiting for a clock edge
    always begin : amon
        @(negedge rstn);
        #1;
        chk("arst_state",  longint'(rm_if.state),      0);
        chk("arst_cycle",  longint'(rm_if.cycle_cnt),  0);
        chk("arst_retire", longint'(rm_if.retire_cnt), 0);
        chk("arst_lastpc", longint'(rm_if.last_pc),    0);
        chk("arst_halted", longint'(rm_if.halted),     0);
        chk("arst_tmo",    longint'(rm_if.timeout),    0);
        chk("arst_hist",   longint'(rm_if.hist_pc),    0);
    end

    initial begin
        bit          v, c;
        logic [31:0] pc;
        int          pct;

        rm_if.wb_valid = 1'b0; rm_if.pcW = '0; rm_if.clr = 1'b0; rm_if.hist_idx = '0;
        model_reset();

        // straight-line program to the halt address
        reset_pulse();
        for (int i = 0; i <= 30; i++) cycle(1'b1, 32'(i * 4), 1'b0, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("prog_halted", longint'(rm_if.halted),     1);
        chk("prog_retire", longint'(rm_if.retire_cnt), 31);
        chk("prog_cycle",  longint'(rm_if.cycle_cnt),  30);
        chk("prog_lastpc", longint'(rm_if.last_pc),    32'h78);

        // ring wrap after 10 retirements
        reset_pulse();
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), 1'b0, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        #1;
`ifdef RETIRE_TRACE_EN
        chk("hist_newest", longint'(rm_if.hist_pc), 32'h24);
`else
        chk("hist_off0",   longint'(rm_if.hist_pc), 0);
`endif
        cycle(1'b0, 32'h0, 1'b0, 3'd7);
        #1;
`ifdef RETIRE_TRACE_EN
        chk("hist_oldest", longint'(rm_if.hist_pc), 32'h8);
`else
        chk("hist_off7",   longint'(rm_if.hist_pc), 0);
`endif

        // watchdog expiry
        reset_pulse();
        cycle(1'b1, 32'h100, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("wdog_early", longint'(rm_if.timeout), 0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("wdog_tmo",   longint'(rm_if.timeout), 1);
        chk("wdog_state", longint'(rm_if.state),   3);
        cycle(1'b1, 32'h104, 1'b0, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("wdog_cyc_frozen", longint'(rm_if.cycle_cnt),  8);
        chk("wdog_ret_frozen", longint'(rm_if.retire_cnt), 1);

        // halt coinciding with the last idle slot before expiry
        reset_pulse();
        cycle(1'b1, 32'h100, 1'b0, 3'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b0, 3'd0);
        cycle(1'b1, HALT, 1'b0, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("race_state", longint'(rm_if.state),   2);
        chk("race_tmo",   longint'(rm_if.timeout), 0);

        // clear overrides a coincident retirement
        reset_pulse();
        cycle(1'b1, 32'h10, 1'b0, 3'd0);
        cycle(1'b1, 32'h14, 1'b0, 3'd0);
        cycle(1'b1, 32'h18, 1'b1, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        chk("clr_state",  longint'(rm_if.state),      0);
        chk("clr_retire", longint'(rm_if.retire_cnt), 0);
        chk("clr_lastpc", longint'(rm_if.last_pc),    0);

        // asynchronous reset mid-run
        cycle(1'b1, 32'h4, 1'b0, 3'd0);
        cycle(1'b1, 32'h8, 1'b0, 3'd0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0);
        reset_pulse();

        // random traffic, alternating busy and sparse phases
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                pct = ((k / 100) % 2 == 1) ? 20 : 85;
                v   = ($urandom_range(0, 99) < pct);
                c   = ($urandom_range(0, 39) == 0);
                pc  = ($urandom_range(0, 24) == 0) ? HALT : (32'($urandom_range(0, 255)) << 2);
                cycle(v, pc, c, 3'($urandom_range(0, 7)));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", longint'(expq.size()), 0);
        if (n_checks < 12) begin
            n_errors++;
            $display("FAIL check_count: got %0d expected >= 12", n_checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 SHALL have parameter HALT_ADDR, default 32'h00000078, the writeback PC whose retirement ends the program.
REQ-002 SHALL have parameter WDOG_LIMIT, default 1024, the maximum consecutive RUN cycles allowed without a retirement.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port pcW, input, `ADDR_SIZE, PC of the instruction in writeback.
REQ-006 SHALL have port wb_valid, input, 1, a real instruction (not a bubble) retires this cycle.
REQ-007 SHALL have port clr, input, 1, synchronous soft clear.
REQ-008 SHALL have port state, output, 2, FSM state.
REQ-009 SHALL have port cycle_cnt, output, 32, RUN cycles elapsed.
REQ-010 SHALL have port retire_cnt, output, 32, instructions retired.
REQ-011 SHALL have port last_pc, output, `ADDR_SIZE, PC of the most recent retirement.
REQ-012 SHALL have port halted, output, 1, program reached HALT_ADDR.
REQ-013 SHALL have port timeout, output, 1, watchdog expired.
REQ-014 SHALL have ports hist_idx, input, 3, and hist_pc, output, `ADDR_SIZE, for trace readback (see Configuration).

Function
REQ-015 SHALL implement states IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
REQ-016 SHALL go IDLE->RUN on the first wb_valid; a first retirement at HALT_ADDR goes IDLE->HALTED directly.
REQ-017 SHALL go RUN->HALTED on the edge where wb_valid=1 and pcW==HALT_ADDR; halted is asserted from the following cycle (1-cycle latency).
REQ-018 SHALL keep an internal idle counter that clears on wb_valid, increments on each RUN cycle without wb_valid, and goes RUN->TIMEOUT when it would reach WDOG_LIMIT.
REQ-019 SHALL, when a halt retirement and watchdog expiry coincide, take HALTED.
REQ-020 SHALL make HALTED and TIMEOUT sticky until clr or reset; retirements in these states are ignored, with no counter, last_pc or history updates.
REQ-021 SHALL increment cycle_cnt on every edge in RUN, including the halting edge.
REQ-022 SHALL increment retire_cnt on every accepted wb_valid, including the first and the halting retirement.
REQ-023 SHALL saturate both counters at 32'hFFFFFFFF, with no wrap.
REQ-024 SHALL load last_pc from pcW on every accepted retirement.
REQ-025 SHALL, when clr=1, return to IDLE and zero all counters, last_pc and history on that edge; clr overrides a coincident wb_valid.
REQ-026 SHALL drive halted = (state==HALTED) and timeout = (state==TIMEOUT).

Reset
REQ-027 SHALL on rstn=0 immediately force state=IDLE and cycle_cnt, retire_cnt, last_pc, hist_pc, halted, timeout and the idle counter to 0, including mid-RUN.
REQ-028 SHALL resume normal operation on the first rising clk edge after rstn deasserts.

Configuration
REQ-029 SHALL, with RETIRE_TRACE_EN defined, keep an 8-entry ring of retired PCs written on each accepted retirement; write pointer wraps 7->0; hist_pc = entry (wptr-1-hist_idx) mod 8, combinational, so hist_idx=0 is the newest.
REQ-030 SHALL, without RETIRE_TRACE_EN, instantiate no history storage and tie hist_pc to 0.

Structure
REQ-031 SHALL take `ADDR_SIZE and the four state encodings from the shared xgriscv_defines.v.
REQ-032 SHALL put the ring buffer in sub-module retire_hist_buf, instantiated only under RETIRE_TRACE_EN.

Verification
REQ-033 SHALL check: reset, then retire PCs 0x0, 0x4, ... 0x78 (31 retirements, 1 per cycle) -> halted=1 on the cycle after 0x78 retires; retire_cnt=31; cycle_cnt=30; last_pc=0x78.
REQ-034 SHALL check: WDOG_LIMIT=8, retire once, then wb_valid=0 -> timeout=1 after 8 idle cycles; state=3; counters frozen.
REQ-035 SHALL check: idle counter at 7 of 8, and wb_valid=1 with pcW=0x78 on the same edge -> HALTED, timeout=0.
REQ-036 SHALL check: rstn pulsed low mid-RUN, between clock edges -> all outputs 0 before the next edge.
REQ-037 SHALL check, with RETIRE_TRACE_EN: retire PCs 0x0..0x24 (10 retirements) -> hist_idx=0 gives 0x24 and hist_idx=7 gives 0x8 (wrap verified); without the macro, hist_pc=0.
REQ-038 SHALL check: clr=1 together with wb_valid=1 in RUN -> next cycle IDLE, retire_cnt=0, last_pc=0.
